// File: rtl/video_awb_div_pkg.sv
// Shared widths, FSM states and constants for the AWB gain divider.
package video_awb_div_pkg;

    localparam int DIVIDEND_W = 24;
    localparam int DIVISOR_W  = 12;
    localparam int QUOT_W     = 12;
    localparam int CNT_W      = $clog2(QUOT_W);

    localparam logic [QUOT_W-1:0] QUOT_SAT = '1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/video_awb_udiv_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract the divisor if it fits.
module video_awb_udiv_step
    import video_awb_div_pkg::*;
(
    input  logic [DIVISOR_W:0]   p_in,
    input  logic                 d_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   p_out,
    output logic                 q_bit
);

    logic [DIVISOR_W+1:0] t;
    logic [DIVISOR_W:0]   sub;

    always_comb begin
        t     = {p_in, d_bit};
        // p_in < divisor keeps t - divisor below 2^DIVISOR_W, so the low bits suffice.
        sub   = t[DIVISOR_W:0] - {1'b0, divisor};
        q_bit = (t >= {2'b00, divisor});
        p_out = q_bit ? sub : t[DIVISOR_W:0];
    end

endmodule

// File: rtl/video_awb_udiv_seq_24ns_12ns_12.sv
// Sequential unsigned restoring divider (24/12 -> 12q, 12r), one quotient bit per clock,
// with saturation on overflow and divide-by-zero flagged in a single cycle.
module video_awb_udiv_seq_24ns_12ns_12
    import video_awb_div_pkg::*;
(
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  ovf,
    output logic                  dbz
);

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [DIVISOR_W:0]   p;
    logic [QUOT_W-1:0]    sh;
    logic [DIVISOR_W-1:0] dvsr;
    logic [DIVISOR_W:0]   p_nxt;
    logic                 q_bit;
    logic                 accept, is_zero, is_ovf, last_iter;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && (state == IDLE);
    assign is_zero   = (divisor == '0);
    assign is_ovf    = !is_zero && (dividend[DIVIDEND_W-1:QUOT_W] >= divisor);
    assign last_iter = (cnt == CNT_W'(QUOT_W - 1));

    video_awb_udiv_step u_step (
        .p_in    (p),
        .d_bit   (sh[QUOT_W-1]),
        .divisor (dvsr),
        .p_out   (p_nxt),
        .q_bit   (q_bit)
    );

    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = (is_zero || is_ovf) ? DONE : CALC;
            CALC:    if (last_iter) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // The dividend shift register doubles as the quotient register: dividend bits
    // leave at the MSB while quotient bits enter at the LSB.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt       <= '0;
            p         <= '0;
            sh        <= '0;
            dvsr      <= '0;
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
        end else if (accept) begin
            cnt  <= '0;
            dvsr <= divisor;
            p    <= {1'b0, dividend[DIVIDEND_W-1:QUOT_W]};
            sh   <= dividend[QUOT_W-1:0];
            if (is_zero || is_ovf) begin
                quotient  <= QUOT_SAT;
                remainder <= '0;
                ovf       <= is_ovf;
                dbz       <= is_zero;
            end
        end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            p   <= p_nxt;
            sh  <= {sh[QUOT_W-2:0], q_bit};
            if (last_iter) begin
                quotient  <= {sh[QUOT_W-2:0], q_bit};
                remainder <= p_nxt[DIVISOR_W-1:0];
                ovf       <= 1'b0;
                dbz       <= 1'b0;
            end
        end
    end

endmodule
